// File: rtl/pong_disp_pkg.sv
// Shared types and constants for the Pong score display path: scheduler state,
// digit indices, parameter defaults and converter latency.
package pong_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLASH = 2'd2
  } disp_state_t;

  localparam logic DIGIT_P1 = 1'b0;
  localparam logic DIGIT_P2 = 1'b1;

  localparam int unsigned SCAN_PERIOD_DEF = 25000;
  localparam int unsigned FLASH_HALF_DEF  = 6250000;
  localparam int unsigned FLASH_COUNT_DEF = 3;
  localparam int unsigned WIN_SCORE_DEF   = 9;

  // Registered stages inside the shared binary-to-7-segment converter.
  localparam int unsigned CONV_LATENCY = 1;

  // Counter width for a terminal value of n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [1:0] digit_onehot(input logic idx);
    return (idx == DIGIT_P2) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Terminal-count counter with enable and synchronous clear; tick is high during
// the last count of every PERIOD-cycle run while enabled.
module pulse_timer
  import pong_disp_pkg::*;
#(
  parameter int unsigned PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W    = cnt_width(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] count;

  assign tick = en && !clr && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/score_digit_scheduler.sv
// Scans two Pong score digits through one shared 7-segment converter and blinks
// digits after score changes. Optional win flash: define SCORE_WIN_FLASH_EN.
module score_digit_scheduler
  import pong_disp_pkg::*;
#(
  parameter int unsigned SCAN_PERIOD = SCAN_PERIOD_DEF,
  parameter int unsigned FLASH_HALF  = FLASH_HALF_DEF,
  parameter int unsigned FLASH_COUNT = FLASH_COUNT_DEF,
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Game_Active,
  input  logic [3:0] i_P1_Score,
  input  logic [3:0] i_P2_Score,
  input  logic       i_Score_Valid,
  output logic       o_Update_Ack,
  output logic [3:0] o_Binary_Num,
  output logic [1:0] o_Digit_En,
  output logic       o_Blank
);

  if (SCAN_PERIOD < 2 || FLASH_COUNT < 1 || WIN_SCORE > 15) begin : g_bad_cfg
    $error("score_digit_scheduler: unsupported parameter set");
  end

  localparam int unsigned  HW        = cnt_width(2 * FLASH_COUNT);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * FLASH_COUNT - 1);

  disp_state_t   state;
  logic [3:0]    p1_score;
  logic [3:0]    p2_score;
  logic          digit_idx;
  logic          idx_pipe [CONV_LATENCY];
  logic [1:0]    flash_mask;
  logic [HW-1:0] half_cnt;

  logic       accept;
  logic [1:0] new_mask;
  logic       flash_start;
  logic       flash_off;
  logic [1:0] off_mask;
  logic [1:0] next_en;
  logic       scan_tick;
  logic       blink_tick;
  logic       blink_en;
  logic       blink_clr;

  // A request seen during its own ack cycle is the same request, not a new one.
  assign accept      = i_Score_Valid && !o_Update_Ack;
  assign new_mask    = {i_P2_Score != p2_score, i_P1_Score != p1_score};
  assign flash_start = accept && (new_mask != 2'b00) && (state != IDLE) && i_Game_Active;
  assign flash_off   = (state == FLASH) && !half_cnt[0];

`ifdef SCORE_WIN_FLASH_EN
  localparam logic [4:0] WIN_LEVEL = 5'(WIN_SCORE);

  logic [1:0] win_mask;
  logic       win_active;
  logic       win_off;

  assign win_mask   = {({1'b0, p2_score} >= WIN_LEVEL), ({1'b0, p1_score} >= WIN_LEVEL)}
                      & {2{state != IDLE}};
  assign win_active = (win_mask != 2'b00);
  assign blink_en   = (state == FLASH) || win_active;
  assign blink_clr  = flash_start || !blink_en;
  // Win blinking overrides update blinking on the digits that reached the win score.
  assign off_mask   = (win_mask & {2{win_off}}) | (flash_mask & ~win_mask & {2{flash_off}});

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      win_off <= 1'b1;
    end else if (!win_active) begin
      win_off <= 1'b1;
    end else if (blink_tick) begin
      win_off <= !win_off;
    end
  end
`else
  assign blink_en  = (state == FLASH);
  assign blink_clr = flash_start || (state != FLASH);
  assign off_mask  = flash_mask & {2{flash_off}};
`endif

  pulse_timer #(.PERIOD(SCAN_PERIOD)) u_scan_timer (
    .clk  (i_Clk),
    .rst_n(i_Rst_L),
    .en   (state != IDLE),
    .clr  (state == IDLE),
    .tick (scan_tick)
  );

  pulse_timer #(.PERIOD(FLASH_HALF)) u_blink_timer (
    .clk  (i_Clk),
    .rst_n(i_Rst_L),
    .en   (blink_en),
    .clr  (blink_clr),
    .tick (blink_tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_en = 2'b00;
    if (state != IDLE && i_Game_Active) begin
      next_en = digit_onehot(idx_pipe[CONV_LATENCY-1]) & ~off_mask;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= IDLE;
      p1_score     <= '0;
      p2_score     <= '0;
      digit_idx    <= DIGIT_P1;
      for (int i = 0; i < CONV_LATENCY; i++) idx_pipe[i] <= DIGIT_P1;
      flash_mask   <= '0;
      half_cnt     <= '0;
      o_Update_Ack <= 1'b0;
      o_Binary_Num <= '0;
      o_Digit_En   <= 2'b00;
      o_Blank      <= 1'b1;
    end else begin
      o_Update_Ack <= accept;
      if (accept) begin
        p1_score <= i_P1_Score;
        p2_score <= i_P2_Score;
      end

      // Enables trail the converter input by its latency so segments and digit line up.
      idx_pipe[0] <= digit_idx;
      for (int i = 1; i < CONV_LATENCY; i++) idx_pipe[i] <= idx_pipe[i-1];
      o_Binary_Num <= (digit_idx == DIGIT_P2) ? p2_score : p1_score;
      o_Digit_En   <= next_en;
      o_Blank      <= (next_en == 2'b00);

      case (state)
        IDLE: begin
          digit_idx  <= DIGIT_P1;
          flash_mask <= '0;
          half_cnt   <= '0;
          if (i_Game_Active) state <= SCAN;
        end
        SCAN, FLASH: begin
          if (scan_tick) digit_idx <= ~digit_idx;
          if (!i_Game_Active) begin
            state      <= IDLE;
            digit_idx  <= DIGIT_P1;
            flash_mask <= '0;
            half_cnt   <= '0;
          end else if (flash_start) begin
            state      <= FLASH;
            flash_mask <= (state == FLASH) ? (flash_mask | new_mask) : new_mask;
            half_cnt   <= '0;
          end else if (state == FLASH && blink_tick) begin
            if (half_cnt == HALF_LAST) begin
              state      <= SCAN;
              flash_mask <= '0;
              half_cnt   <= '0;
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_digit_scheduler.sv
// Self-checking bench for score_digit_scheduler: handshake scoreboard plus
// scan, flash, idle and reset checks on small parameters.
module tb_score_digit_scheduler;

  localparam int SP = 4;
  localparam int FH = 8;
  localparam int FC = 2;
  localparam int WS = 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game;
  logic [3:0] p1_in;
  logic [3:0] p2_in;
  logic       valid;
  logic       ack;
  logic [3:0] bn;
  logic [1:0] de;
  logic       blank;

  typedef struct packed {
    logic [3:0] p1;
    logic [3:0] p2;
  } scores_t;

  scores_t    exp_q[$];
  scores_t    shown;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] bn_log [0:127];
  logic [1:0] de_log [0:127];

  score_digit_scheduler #(
    .SCAN_PERIOD(SP),
    .FLASH_HALF (FH),
    .FLASH_COUNT(FC),
    .WIN_SCORE  (WS)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Game_Active(game),
    .i_P1_Score   (p1_in),
    .i_P2_Score   (p2_in),
    .i_Score_Valid(valid),
    .o_Update_Ack (ack),
    .o_Binary_Num (bn),
    .o_Digit_En   (de),
    .o_Blank      (blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus keeps P1 scores below 7 and P2 scores at 7 or above, so a shown
  // value identifies which digit it belongs to.
  function automatic logic digit_of(input logic [3:0] v);
    return v >= 4'd7;
  endfunction

  function automatic logic [1:0] onehot(input logic d);
    return d ? 2'b10 : 2'b01;
  endfunction

  // k counts edges after the accepting edge; enables show the off phases one clock late.
  function automatic bit in_off(input int k);
    return k >= 1 && k <= 2 * FC * FH && (((k - 1) / FH) % 2 == 0);
  endfunction

  task automatic update(input logic [3:0] a, input logic [3:0] b);
    scores_t s;
    int      lat;
    s.p1 = a;
    s.p2 = b;
    exp_q.push_back(s);
    p1_in = a;
    p2_in = b;
    valid = 1'b1;
    lat   = 0;
    do begin
      step();
      lat++;
    end while (!ack && lat < 10);
    check("ack_latency", lat, 1);
    valid = 1'b0;
    shown = exp_q.pop_front();
  endtask

  // Samples n edges after the current one; sup marks digits expected to blink.
  task automatic capture(input int n, input logic [1:0] sup);
    logic [1:0] exp_de;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) step();
      bn_log[k] = bn;
      de_log[k] = de;
      if (k > 0) begin
        exp_de = onehot(digit_of(bn_log[k-1])) & ~(in_off(k) ? sup : 2'b00);
        check("digit_en", de, exp_de);
        check("blank", blank, exp_de == 2'b00);
        check("ack_idle", ack, 0);
        if (k >= 2 && de != 2'b00)
          check("score_shown", bn_log[k-1], de[1] ? shown.p2 : shown.p1);
      end
    end
  endtask

  task automatic wait_first(input logic [3:0] exp_bn);
    logic [3:0] prev_bn;
    int         n;
    n = 0;
    do begin
      prev_bn = bn;
      step();
      n++;
    end while (de == 2'b00 && n < 10);
    check("first_digit", de, 2'b01);
    check("first_value", prev_bn, exp_bn);
  endtask

  initial begin
    int f;
    int ones;
    rst_n = 1'b0;
    game  = 1'b0;
    valid = 1'b0;
    p1_in = '0;
    p2_in = '0;
    shown = '0;
    repeat (3) step();
    check("rst_ack", ack, 0);
    check("rst_num", bn, 0);
    check("rst_en", de, 0);
    check("rst_blank", blank, 1);
    rst_n = 1'b1;
    step();

    // Update while idle: acked, display stays dark.
    update(4'd3, 4'd7);
    repeat (3) step();
    check("idle_dark", de, 0);
    check("idle_blank", blank, 1);

    // Start scanning: digit 0 first, values alternate every SP clocks.
    game = 1'b1;
    wait_first(4'd3);
    capture(24, 2'b00);
    f = 0;
    for (int t = 1; t <= 24; t++) if (f == 0 && bn_log[t] == 4'd7) f = t;
    check("scan_toggle_found", f > 0, 1);
    if (f > 0)
      for (int t = f; t <= 24; t++)
        check("scan_period", bn_log[t], (((t - f) / SP) % 2 == 0) ? 4'd7 : 4'd3);

    // P1 change: digit 0 blinks, then scanning resumes.
    update(4'd4, 4'd7);
    capture(40, 2'b01);

    // Identical scores: ack only.
    update(4'd4, 4'd7);
    capture(16, 2'b00);

    // P2 change, then a P1 change mid-flash restarts with both digits masked.
    update(4'd4, 4'd8);
    capture(11, 2'b10);
    update(4'd5, 4'd8);
    capture(40, 2'b11);

    // Game drops during a flash while an update is pending.
    update(4'd6, 4'd8);
    capture(5, 2'b01);
    begin
      scores_t s;
      s.p1 = 4'd2;
      s.p2 = 4'd8;
      exp_q.push_back(s);
    end
    game  = 1'b0;
    p1_in = 4'd2;
    p2_in = 4'd8;
    valid = 1'b1;
    step();
    check("drop_ack", ack, 1);
    check("drop_dark", de, 0);
    check("drop_blank", blank, 1);
    valid = 1'b0;
    shown = exp_q.pop_front();
    repeat (4) step();
    check("idle_hold", de, 0);
    game = 1'b1;
    wait_first(4'd2);
    capture(16, 2'b00);

`ifdef SCORE_WIN_FLASH_EN
    // P2 reaches the win score: digit 1 blinks for as long as the game runs.
    update(4'd2, 4'd9);
    for (int j = 0; j < 10; j++) begin
      ones = 0;
      for (int c = 0; c < FH; c++) begin
        step();
        ones += int'(de[1]);
      end
      if (j % 2 == 0) check("win_off_phase", ones, 0);
      else            check("win_on_phase", ones > 0, 1);
    end
    game = 1'b0;
    step();
    check("win_stop", de, 0);
    ones = 0;
    repeat (20) begin
      step();
      ones += int'(de != 2'b00);
    end
    check("win_idle_dark", ones, 0);
    game = 1'b1;
    wait_first(4'd2);
`endif

    // Asynchronous reset in the middle of a clock period while scanning.
    repeat (6) step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_num", bn, 0);
    check("async_rst_en", de, 0);
    check("async_rst_blank", blank, 1);
    check("async_rst_ack", ack, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
